demux_1_n_stream: RTL and testbench

//  Parametrised, registered 1-to-N_CH streaming demultiplexer; successor to the combinational 1-to-8 demux.

---
 rtl/demux_pkg.sv | 15 +
 rtl/demux_ch_reg.sv | 27 ++
 rtl/demux_1_n_stream.sv | 84 ++++++++
 tb/tb_demux_1_n_stream.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared mode encodings and sizing helper for the 1-to-N streaming demux.
package demux_pkg;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_RR   = 1'b1;

  // Channel-select width: ceil(log2 n), never below 1 bit.
  function automatic int unsigned sel_w(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/demux_ch_reg.sv
// One-entry valid/ready holding register for a single demux output channel.
module demux_ch_reg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic              drain,
  output logic              valid,
  output logic [DATA_W-1:0] data_out
);

  // A load always wins over a drain so back-to-back beats leave no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      data_out <= '0;
    end else if (load) begin
      valid    <= 1'b1;
      data_out <= data;
    end else if (drain) begin
      valid    <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1_n_stream.sv
// Registered 1-to-N_CH stream demux with address or round-robin routing.
// Optional broadcast port i_bcast is enabled by defining DEMUX_BCAST_EN.
module demux_1_n_stream
  import demux_pkg::*;
#(
  parameter  int unsigned N_CH   = 8,
  parameter  int unsigned DATA_W = 8,
  localparam int unsigned SEL_W  = sel_w(N_CH)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [DATA_W-1:0]        i_data,
  input  logic [SEL_W-1:0]         i_sel,
  input  logic                     i_mode,
`ifdef DEMUX_BCAST_EN
  input  logic                     i_bcast,
`endif
  output logic [N_CH-1:0]          o_valid,
  input  logic [N_CH-1:0]          i_ready,
  output logic [N_CH*DATA_W-1:0]   o_data,
  output logic [SEL_W-1:0]         o_cur_ch,
  output logic                     o_err
);

  logic [SEL_W-1:0] tgt;
  logic             bcast;
  logic             sel_oor;
  logic             accept;
  logic [N_CH-1:0]  ch_rdy;
  logic [N_CH-1:0]  load;
  logic [N_CH-1:0]  drain;

  // Target decode and input handshake; an out-of-range select matches no channel.
  always_comb begin
    bcast = 1'b0;
`ifdef DEMUX_BCAST_EN
    bcast = i_bcast;
`endif
    tgt     = (i_mode == MODE_RR) ? o_cur_ch : i_sel;
    sel_oor = (i_mode == MODE_ADDR) && (32'(i_sel) >= N_CH) && !bcast;
    ch_rdy  = ~o_valid | i_ready;
    drain   = o_valid & i_ready;
    o_ready = sel_oor;
    for (int k = 0; k < int'(N_CH); k++) begin
      if (tgt == SEL_W'(k)) o_ready = ch_rdy[k];
    end
    if (bcast) o_ready = &ch_rdy;
    accept = i_valid & o_ready;
    load   = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      load[k] = accept & (bcast | (tgt == SEL_W'(k)));
    end
  end

  // Round-robin pointer advances only on accepted single-channel beats.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_cur_ch <= '0;
      o_err    <= 1'b0;
    end else begin
      o_err <= accept & sel_oor;
      if (accept && (i_mode == MODE_RR) && !bcast) begin
        o_cur_ch <= (o_cur_ch == SEL_W'(N_CH - 1)) ? '0 : o_cur_ch + SEL_W'(1);
      end
    end
  end

  for (genvar k = 0; k < int'(N_CH); k++) begin : g_ch
    demux_ch_reg #(
      .DATA_W (DATA_W)
    ) u_ch (
      .clk      (i_clk),
      .rst      (i_rst),
      .load     (load[k]),
      .data     (i_data),
      .drain    (drain[k]),
      .valid    (o_valid[k]),
      .data_out (o_data[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_demux_1_n_stream.sv
// Bench for demux_1_n_stream: an 8-channel and a 6-channel instance share one stimulus stream.
module tb_demux_1_n_stream;

  logic        clk;
  logic        rst, valid, mode, bcast;
  logic [2:0]  sel;
  logic [7:0]  data;
  logic [7:0]  rdy;
  logic        r8, r6, e8, e6;
  logic [7:0]  v8;
  logic [5:0]  v6;
  logic [63:0] d8;
  logic [47:0] d6;
  logic [2:0]  p8, p6;

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  demux_1_n_stream #(.N_CH(8), .DATA_W(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(r8), .i_data(data),
    .i_sel(sel), .i_mode(mode),
`ifdef DEMUX_BCAST_EN
    .i_bcast(bcast),
`endif
    .o_valid(v8), .i_ready(rdy), .o_data(d8), .o_cur_ch(p8), .o_err(e8)
  );

  demux_1_n_stream #(.N_CH(6), .DATA_W(8)) dut6 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(r6), .i_data(data),
    .i_sel(sel), .i_mode(mode),
`ifdef DEMUX_BCAST_EN
    .i_bcast(bcast),
`endif
    .o_valid(v6), .i_ready(rdy[5:0]), .o_data(d6), .o_cur_ch(p6), .o_err(e6)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per-instance channel occupancy, contents, pointer, error flag.
  logic       m_v [2][8];
  logic [7:0] m_d [2][8];
  int         m_p [2];
  logic       m_e [2];

  function automatic int n_of(input int d);
    return (d == 0) ? 8 : 6;
  endfunction

  function automatic logic model_ready(input int d);
    int n, t;
    n = n_of(d);
    if (bcast) begin
      for (int k = 0; k < n; k++) if (m_v[d][k] && !rdy[k]) return 1'b0;
      return 1'b1;
    end
    t = mode ? m_p[d] : int'(sel);
    if (t >= n) return 1'b1;
    return !m_v[d][t] || rdy[t];
  endfunction

  always @(posedge clk) begin : model
    int n, t;
    logic acc;
    for (int d = 0; d < 2; d++) begin
      n   = n_of(d);
      acc = valid && model_ready(d);
      t   = mode ? m_p[d] : int'(sel);
      m_e[d] = 1'b0;
      if (rst) begin
        for (int k = 0; k < 8; k++) begin
          m_v[d][k] = 1'b0;
          m_d[d][k] = 8'h00;
        end
        m_p[d] = 0;
      end else begin
        for (int k = 0; k < n; k++) if (m_v[d][k] && rdy[k]) m_v[d][k] = 1'b0;
        if (acc) begin
          if (bcast) begin
            for (int k = 0; k < n; k++) begin
              m_v[d][k] = 1'b1;
              m_d[d][k] = data;
            end
          end else if (t >= n) begin
            m_e[d] = 1'b1;
          end else begin
            m_v[d][t] = 1'b1;
            m_d[d][t] = data;
            if (mode) m_p[d] = (m_p[d] + 1) % n;
          end
        end
      end
    end
  end

  // Compare every cycle on the falling edge, away from input changes and register updates.
  always @(negedge clk) begin : compare
    logic [7:0]  ev;
    logic [63:0] ed, ad;
    for (int d = 0; d < 2; d++) begin
      ev = '0;
      ed = '0;
      ad = '0;
      for (int k = 0; k < n_of(d); k++) begin
        ev[k] = m_v[d][k];
        if (m_v[d][k]) begin
          ed[k*8 +: 8] = m_d[d][k];
          ad[k*8 +: 8] = (d == 0) ? d8[k*8 +: 8] : d6[k*8 +: 8];
        end
      end
      check($sformatf("ready_n%0d", n_of(d)), 64'((d == 0) ? r8 : r6), 64'(model_ready(d)));
      check($sformatf("valid_n%0d", n_of(d)), 64'((d == 0) ? v8 : {2'b00, v6}), 64'(ev));
      check($sformatf("data_n%0d", n_of(d)), ad, ed);
      check($sformatf("ptr_n%0d", n_of(d)), 64'((d == 0) ? p8 : p6), 64'(m_p[d]));
      check($sformatf("err_n%0d", n_of(d)), 64'((d == 0) ? e8 : e6), 64'(m_e[d]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; mode = 1'b0; bcast = 1'b0;
    sel = '0; data = '0; rdy = '1;
    step();
    step();
    check("rst_valid", 64'(v8), 64'h0);
    check("rst_data", d8, 64'h0);
    check("rst_ptr", 64'(p8), 64'h0);
    rst = 1'b0;

    // Address routing across every channel.
    for (int s = 0; s < 8; s++) begin
      valid = 1'b1; sel = 3'(s); data = 8'hA0 + 8'(s);
      step();
      check("addr_valid", 64'(v8), 64'(8'h01 << s));
      check("addr_data", 64'(d8[s*8 +: 8]), 64'(8'hA0 + 8'(s)));
      if (s == 6) check("oor_err_sel6", 64'(e6), 64'h1);
    end
    valid = 1'b0;
    step();

    // Round-robin: 10 beats wrap the 8-channel pointer to 2.
    mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      valid = 1'b1; data = 8'(i);
      step();
      check("rr_data", 64'(d8[(i % 8)*8 +: 8]), 64'(i));
    end
    valid = 1'b0;
    check("rr_ptr8", 64'(p8), 64'h2);
    check("rr_ptr6", 64'(p6), 64'h4);
    step();

    // Stall channel 3: first beat held, second waits, then loads with no bubble.
    mode = 1'b0; rdy[3] = 1'b0;
    valid = 1'b1; sel = 3'd3; data = 8'h11;
    step();
    data = 8'h22;
    #1;
    check("stall_ready", 64'(r8), 64'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", 64'({v8[3], d8[31:24]}), 64'h111);
    end
    rdy[3] = 1'b1;
    #1;
    check("unstall_ready", 64'(r8), 64'h1);
    step();
    check("refill", 64'({v8[3], d8[31:24]}), 64'h122);
    valid = 1'b0;
    step();

    // Out-of-range select on the 6-channel instance.
    valid = 1'b1; sel = 3'd7; data = 8'hFF;
    #1;
    check("oor_ready", 64'(r6), 64'h1);
    step();
    check("oor_err", 64'(e6), 64'h1);
    check("oor_novalid", 64'(v6), 64'h0);
    valid = 1'b0;
    step();
    check("oor_err_pulse", 64'(e6), 64'h0);

    // Reset with channels 2 and 5 full.
    rdy = '0; valid = 1'b1; sel = 3'd2; data = 8'h22;
    step();
    sel = 3'd5; data = 8'h55;
    step();
    valid = 1'b0;
    check("pre_rst_valid", 64'(v8), 64'h24);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", 64'(v8), 64'h0);
    check("mid_rst_data", d8, 64'h0);
    check("mid_rst_ptr", 64'(p8), 64'h0);
    rdy = '1;
    step();

`ifdef DEMUX_BCAST_EN
    // Broadcast waits for the stalled channel, then fills every channel.
    rdy[4] = 1'b0; valid = 1'b1; sel = 3'd4; data = 8'h44;
    step();
    bcast = 1'b1; data = 8'h5A;
    #1;
    check("bcast_ready_lo", 64'(r8), 64'h0);
    step();
    step();
    rdy[4] = 1'b1;
    #1;
    check("bcast_ready_hi", 64'(r8), 64'h1);
    step();
    valid = 1'b0; bcast = 1'b0; rdy = '0;
    check("bcast_data", d8, {8{8'h5A}});
    check("bcast_valid", 64'(v8), 64'hFF);
    check("bcast_ptr", 64'(p8), 64'h0);
    rdy = '1;
    step();
`endif

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      valid = ($urandom_range(3) != 0);
      mode  = ($urandom_range(2) == 0);
      sel   = 3'($urandom);
      data  = 8'($urandom);
      rdy   = 8'($urandom);
      rst   = ($urandom_range(96) == 0);
`ifdef DEMUX_BCAST_EN
      bcast = ($urandom_range(15) == 0);
`endif
      step();
    end
    valid = 1'b0; rst = 1'b0; bcast = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
